// File: rtl/ppu_pkg.sv
// ppu_pkg: constants and types shared across the posit processing unit.
//   FP32_* : binary32 field widths, exponent bias and the canonical quiet NaN.
//   fp32_t : packed binary32 word {sign, exp, mant}.
package ppu_pkg;

   localparam int          FP32_BIAS   = 127;
   localparam logic [31:0] FP32_QNAN   = 32'h7FC00000;
   localparam int          FP32_EXP_W  = 8;
   localparam int          FP32_MANT_W = 23;

   typedef struct packed {
      logic                   sign;
      logic [FP32_EXP_W-1:0]  exp;
      logic [FP32_MANT_W-1:0] mant;
   } fp32_t;

endpackage

// File: rtl/posit_regime_lzc.sv
// posit_regime_lzc: measures the regime run of a posit body.
//   body    : in  N-1  magnitude bits of the posit (sign already removed)
//   k       : out      signed regime value (run of 1s -> r-1, run of 0s -> -r)
//   reg_len : out      regime field length in bits, terminator included
//                      unless the run reaches the LSB
//   rest    : out N-1  body shifted left past the regime field, zero filled
module posit_regime_lzc
   import ppu_pkg::*;
#(
   parameter  int N  = 16,
   localparam int KW = $clog2(N) + 2,
   localparam int LW = $clog2(N) + 1
) (
   input  logic [N-2:0]         body,
   output logic signed [KW-1:0] k,
   output logic [LW-1:0]        reg_len,
   output logic [N-2:0]         rest
);

   logic                 lead;
   logic                 done;
   logic [LW-1:0]        run;
   logic signed [KW-1:0] run_s;

   always_comb begin
      lead = body[N-2];
      run  = '0;
      done = 1'b0;
      for (int i = N - 2; i >= 0; i--) begin
         if (!done) begin
            if (body[i] == lead) begin
               run = run + LW'(1);
            end else begin
               done = 1'b1;
            end
         end
      end
   end

   assign run_s   = $signed({1'b0, run});
   assign k       = lead ? (run_s - KW'(1)) : -run_s;
   assign reg_len = (run == LW'(N - 1)) ? run : run + LW'(1);
   assign rest    = body << reg_len;

endmodule

// File: rtl/posit_to_fp32_pipe.sv
// posit_to_fp32_pipe: 3-stage posit<N,ES> to IEEE binary32 converter with a
// valid/ready stream interface.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake, in_posit is the posit operand
//   out_valid / out_ready: output handshake, out_fp32 is the binary32 result
// Stages: S1 sign/negate/regime count, S2 field extraction and exponent add,
// S3 round-to-nearest-even, special cases and output register. All stages
// advance together whenever the output is not stalled.
module posit_to_fp32_pipe
   import ppu_pkg::*;
#(
   parameter int N  = 16,
   parameter int ES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_posit,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_fp32
);

   localparam int KW  = $clog2(N) + 2;
   localparam int LW  = $clog2(N) + 1;
   localparam int BW  = N - 1;
   // fraction is held at least 25 bits wide so mantissa, guard and sticky
   // always exist; short fractions are simply zero padded
   localparam int FX  = (BW > 25) ? BW : 25;
   localparam int ESW = (ES > 0) ? ES : 1;
   localparam int XW  = 11;

   logic stall;
   logic advance;

   assign stall    = out_valid & ~out_ready;
   assign advance  = ~stall;
   assign in_ready = rst | advance;

   // ---------------- S1: sign, negate, regime ----------------
   logic                 in_sign;
   logic [BW-1:0]        in_body;
   logic                 in_zero;
   logic                 in_nar;
   logic signed [KW-1:0] lzc_k;
   logic [LW-1:0]        regime_len_unused; // the shifted body already encodes it
   logic [BW-1:0]        lzc_rest;

   assign in_sign = in_posit[N-1];
   // low N-1 bits of the two's-complement negation equal the negated body
   assign in_body = in_sign ? (~in_posit[N-2:0] + BW'(1)) : in_posit[N-2:0];
   assign in_zero = (in_posit == '0);
   assign in_nar  = in_sign & (in_posit[N-2:0] == '0);

   posit_regime_lzc #(.N(N)) u_lzc (
      .body    (in_body),
      .k       (lzc_k),
      .reg_len (regime_len_unused),
      .rest    (lzc_rest)
   );

   logic                 s1_valid;
   logic                 s1_sign;
   logic                 s1_zero;
   logic                 s1_nar;
   logic signed [KW-1:0] s1_k;
   logic [BW-1:0]        s1_rest;

   // ---------------- S2: exponent field, fraction, scale ----------------
   logic [ESW-1:0]       exp_field;
   logic [BW-1:0]        frac_left;
   logic [FX-1:0]        frac_ext;
   logic signed [XW-1:0] k_ext;
   logic signed [XW-1:0] bexp_sum;

   if (ES == 0) begin : g_no_es
      assign exp_field = '0;
      assign frac_left = s1_rest;
   end else begin : g_es
      assign exp_field = s1_rest[BW-1 -: ES];
      assign frac_left = s1_rest << ES;
   end

   if (FX > BW) begin : g_frac_pad
      assign frac_ext = {frac_left, {(FX - BW){1'b0}}};
   end else begin : g_frac_full
      assign frac_ext = frac_left;
   end

   assign k_ext    = {{(XW - KW){s1_k[KW-1]}}, s1_k};
   assign bexp_sum = (k_ext <<< ES) + {{(XW - ESW){1'b0}}, exp_field} + XW'(FP32_BIAS);

   logic                 s2_valid;
   logic                 s2_sign;
   logic                 s2_zero;
   logic                 s2_nar;
   logic signed [XW-1:0] s2_bexp;
   logic [FX-1:0]        s2_frac;

   // ---------------- S3: rounding and specials ----------------
   logic [22:0]          mant_trunc;
   logic                 guard;
   logic                 sticky;
   logic                 round_up;
   logic [23:0]          mant_rnd;
   logic signed [XW-1:0] bexp_rnd;
   fp32_t                res;

   assign mant_trunc = s2_frac[FX-1 -: 23];
   assign guard      = s2_frac[FX-24];
   assign sticky     = |s2_frac[FX-25:0];
   assign round_up   = guard & (sticky | mant_trunc[0]);
   assign mant_rnd   = {1'b0, mant_trunc} + 24'(round_up);
   assign bexp_rnd   = s2_bexp + XW'(mant_rnd[23]);

   always_comb begin
      res = '0;
      if (s2_zero) begin
         res = '0;
      end else if (s2_nar) begin
         res = fp32_t'(FP32_QNAN);
      end else if (bexp_rnd >= 255) begin
         res.sign = s2_sign;
         res.exp  = '1;
      end else if (bexp_rnd <= 0) begin
         res.sign = s2_sign;
      end else begin
         res.sign = s2_sign;
         res.exp  = bexp_rnd[7:0];
         res.mant = mant_rnd[22:0];
      end
   end

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_fp32  <= '0;
      end else if (advance) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (s2_valid) begin
            out_fp32 <= res;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         s1_sign <= in_sign;
         s1_zero <= in_zero;
         s1_nar  <= in_nar;
         s1_k    <= lzc_k;
         s1_rest <= lzc_rest;
         s2_sign <= s1_sign;
         s2_zero <= s1_zero;
         s2_nar  <= s1_nar;
         s2_bexp <= bexp_sum;
         s2_frac <= frac_ext;
      end
   end

endmodule

// File: tb/tb_posit_to_fp32_pipe.sv
// Bench for posit_to_fp32_pipe: three instances (posit<16,1>, <32,0>, <32,3>)
// share clock and reset; sel chooses which one receives stimulus. Expected
// results come from a value-level posit decoder with integer RNE.
module tb_posit_to_fp32_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_posit;
   logic [1:0]  sel;

   logic        rdy_a, rdy_b, rdy_c;
   logic        ov_a, ov_b, ov_c;
   logic [31:0] of_a, of_b, of_c;
   logic        in_ready_m, out_valid_m;
   logic [31:0] out_fp32_m;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   posit_to_fp32_pipe #(.N(16), .ES(1)) u_p16_es1 (
      .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2'd0), .in_ready(rdy_a),
      .in_posit(in_posit[15:0]), .out_valid(ov_a), .out_ready(out_ready), .out_fp32(of_a));

   posit_to_fp32_pipe #(.N(32), .ES(0)) u_p32_es0 (
      .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2'd1), .in_ready(rdy_b),
      .in_posit(in_posit), .out_valid(ov_b), .out_ready(out_ready), .out_fp32(of_b));

   posit_to_fp32_pipe #(.N(32), .ES(3)) u_p32_es3 (
      .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2'd2), .in_ready(rdy_c),
      .in_posit(in_posit), .out_valid(ov_c), .out_ready(out_ready), .out_fp32(of_c));

   always_comb begin
      in_ready_m  = rdy_a;
      out_valid_m = ov_a;
      out_fp32_m  = of_a;
      if (sel == 2'd1) begin
         in_ready_m  = rdy_b;
         out_valid_m = ov_b;
         out_fp32_m  = of_b;
      end else if (sel == 2'd2) begin
         in_ready_m  = rdy_c;
         out_valid_m = ov_c;
         out_fp32_m  = of_c;
      end
   end

   function automatic int cfg_n(input logic [1:0] s);
      return (s == 2'd0) ? 16 : 32;
   endfunction

   function automatic int cfg_es(input logic [1:0] s);
      return (s == 2'd0) ? 1 : ((s == 2'd1) ? 0 : 3);
   endfunction

   // value = (-1)^s * 2^(k*2^es + e) * 1.f, rounded to 23 fraction bits
   function automatic logic [31:0] ref_fp32(input int n, input int es, input logic [31:0] word);
      longint unsigned p, a, fbits, mant, rem, half;
      int s, k, run, pos, e, f, big_e, sh, lead;
      logic [31:0] r;
      p = 64'(word) & ((64'd1 << n) - 1);
      if (p == 0) return 32'h0;
      if (p == (64'd1 << (n - 1))) return 32'h7FC00000;
      s = int'((p >> (n - 1)) & 1);
      a = (s != 0) ? ((64'd1 << n) - p) : p;
      lead = int'((a >> (n - 2)) & 1);
      run = 0;
      pos = n - 2;
      while (pos >= 0 && int'((a >> pos) & 1) == lead) begin
         run++;
         pos--;
      end
      k = (lead != 0) ? run - 1 : -run;
      pos--;
      e = 0;
      for (int i = 0; i < es; i++) begin
         e = e * 2 + ((pos >= 0) ? int'((a >> pos) & 1) : 0);
         pos--;
      end
      f = (pos >= 0) ? pos + 1 : 0;
      fbits = (f > 0) ? (a & ((64'd1 << f) - 1)) : 64'd0;
      big_e = k * (1 << es) + e;
      if (f <= 23) begin
         mant = fbits << (23 - f);
      end else begin
         sh   = f - 23;
         mant = fbits >> sh;
         rem  = fbits & ((64'd1 << sh) - 1);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && mant[0])) mant++;
      end
      if (mant == (64'd1 << 23)) begin
         mant = 0;
         big_e++;
      end
      big_e += 127;
      r = 32'h0;
      r[31] = s[0];
      if (big_e >= 255) r[30:23] = 8'hFF;
      else if (big_e > 0) begin
         r[30:23] = big_e[7:0];
         r[22:0]  = mant[22:0];
      end
      return r;
   endfunction

   function automatic logic [31:0] rand_word(input int n);
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 9))
         0: w = 32'h0;
         1: w = 32'h1 << (n - 1);
         2: w = (32'h1 << (n - 1)) - 1;
         3: w = 32'h1;
         4: w = 32'hFFFF_FFFF;
         default: ;
      endcase
      return w;
   endfunction

   task automatic run_word(input logic [1:0] s, input logic [31:0] w, input string name);
      logic [31:0] expv;
      int lat;
      sel       = s;
      in_posit  = w;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      expv      = ref_fp32(cfg_n(s), cfg_es(s), w);
      @(negedge clk);
      n_cmp++;
      if (in_ready_m !== 1'b1) begin
         n_err++;
         $display("FAIL %s in_ready: got %b expected 1", name, in_ready_m);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (out_valid_m === 1'b1) begin
            lat = c;
            break;
         end
      end
      n_cmp++;
      if (lat != 3) begin
         n_err++;
         $display("FAIL %s latency: got %0d expected 3", name, lat);
      end
      n_cmp++;
      if (out_fp32_m !== expv) begin
         n_err++;
         $display("FAIL %s value: got %h expected %h", name, out_fp32_m, expv);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_posit  = 32'h4000_4000;
      out_ready = 1'b1;
      sel       = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         n_cmp++;
         if (out_valid_m !== 1'b0) begin
            n_err++;
            $display("FAIL reset out_valid[%0d]: got %b expected 0", s, out_valid_m);
         end
         n_cmp++;
         if (out_fp32_m !== 32'h0) begin
            n_err++;
            $display("FAIL reset out_fp32[%0d]: got %h expected 0", s, out_fp32_m);
         end
         n_cmp++;
         if (in_ready_m !== 1'b1) begin
            n_err++;
            $display("FAIL reset in_ready[%0d]: got %b expected 1", s, in_ready_m);
         end
      end
      sel = 2'd0;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid_m !== 1'b0) begin
            n_err++;
            $display("FAIL reset ignored input: out_valid %b at cycle %0d expected 0", out_valid_m, c);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_directed_n16();
      run_word(2'd0, 32'h4000, "p16 one");
      run_word(2'd0, 32'h5000, "p16 two");
      run_word(2'd0, 32'hC000, "p16 minus one");
      run_word(2'd0, 32'h0000, "p16 zero");
      run_word(2'd0, 32'h8000, "p16 nar");
      run_word(2'd0, 32'h7FFF, "p16 maxpos");
   endtask

   task automatic test_rounding_n32();
      run_word(2'd1, 32'h4000_0001, "rne below half");
      run_word(2'd1, 32'h4000_0040, "rne lsb set");
      run_word(2'd1, 32'h4000_0020, "rne tie even");
      run_word(2'd1, 32'h4000_0060, "rne tie odd");
   endtask

   task automatic test_limits_n32();
      run_word(2'd2, 32'h7FFF_FFFF, "es3 overflow");
      run_word(2'd2, 32'h0000_0001, "es3 underflow");
      run_word(2'd2, 32'hFFFF_FFFF, "es3 neg underflow");
   endtask

   task automatic test_back_to_back();
      logic [31:0] w[8];
      logic [31:0] got[$];
      logic [31:0] held;
      int idx;
      logic exp_rdy;
      sel = 2'd0;
      for (int i = 0; i < 8; i++) w[i] = rand_word(16);
      idx  = 0;
      held = 32'h0;
      for (int c = 0; c < 40 && got.size() < 8; c++) begin
         out_ready = !(c >= 4 && c <= 7);
         in_valid  = (idx < 8);
         in_posit  = (idx < 8) ? w[idx] : 32'h0;
         exp_rdy   = !(c >= 4 && c <= 7);
         @(negedge clk);
         if (c < 12) begin
            n_cmp++;
            if (in_ready_m !== exp_rdy) begin
               n_err++;
               $display("FAIL b2b in_ready cycle %0d: got %b expected %b", c, in_ready_m, exp_rdy);
            end
         end
         if (c == 4) held = out_fp32_m;
         if (c >= 5 && c <= 7) begin
            n_cmp++;
            if (out_fp32_m !== held || out_valid_m !== 1'b1) begin
               n_err++;
               $display("FAIL b2b hold cycle %0d: got %h valid %b expected %h valid 1",
                        c, out_fp32_m, out_valid_m, held);
            end
         end
         if (in_valid && in_ready_m) idx++;
         if (out_valid_m && out_ready) got.push_back(out_fp32_m);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_cmp++;
      if (held !== ref_fp32(16, 1, w[1])) begin
         n_err++;
         $display("FAIL b2b held word: got %h expected %h", held, ref_fp32(16, 1, w[1]));
      end
      n_cmp++;
      if (got.size() != 8) begin
         n_err++;
         $display("FAIL b2b count: got %0d expected 8", got.size());
      end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== ref_fp32(16, 1, w[i])) begin
            n_err++;
            $display("FAIL b2b order %0d: got %h expected %h", i, got[i], ref_fp32(16, 1, w[i]));
         end
      end
   endtask

   task automatic test_random_stream(input logic [1:0] s);
      logic [31:0] exp_q[$];
      logic [31:0] e;
      int sent;
      sel  = s;
      sent = 0;
      for (int c = 0; c < 1000; c++) begin
         if (sent >= 60 && exp_q.size() == 0) break;
         in_valid  = (sent < 60) && ($urandom_range(0, 3) != 0);
         in_posit  = rand_word(cfg_n(s));
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         if (out_valid_m && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL stream%0d extra output: got %h expected none", s, out_fp32_m);
            end else begin
               e = exp_q.pop_front();
               if (out_fp32_m !== e) begin
                  n_err++;
                  $display("FAIL stream%0d value: got %h expected %h", s, out_fp32_m, e);
               end
            end
         end
         if (in_valid && in_ready_m) begin
            exp_q.push_back(ref_fp32(cfg_n(s), cfg_es(s), in_posit));
            sent++;
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_cmp++;
      if (sent != 60 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL stream%0d drain: sent %0d pending %0d expected 60 and 0", s, sent, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_stream();
      logic seen;
      sel       = 2'd0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_posit = 32'h4000 + 32'(i * 32'h0100);
         @(negedge clk);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (in_ready_m !== 1'b1) begin
         n_err++;
         $display("FAIL midrst in_ready during reset: got %b expected 1", in_ready_m);
      end
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (out_valid_m !== 1'b0) begin
         n_err++;
         $display("FAIL midrst out_valid after reset: got %b expected 0", out_valid_m);
      end
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (out_valid_m === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL midrst flushed words: out_valid seen %b expected 0", seen);
      end
      @(posedge clk);
      #1;
      run_word(2'd0, 32'h5000, "midrst next word");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed_n16();
      test_rounding_n32();
      test_limits_n32();
      test_back_to_back();
      test_random_stream(2'd0);
      test_random_stream(2'd1);
      test_random_stream(2'd2);
      test_reset_mid_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
